// File: rtl/eth_tx_framer_if.sv
// Byte-stream interface between the packet builder, the TX framer and the line side.
// The slave modport is the framer's view of it; the master modport is the builder/line view.
interface eth_tx_framer_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_err;
    logic       frame_done;
    logic       underrun;
    logic       busy;

    modport master (
        output s_data, s_valid, s_last,
        input  s_ready, m_data, m_valid, m_err, frame_done, underrun, busy
    );

    modport slave (
        input  s_data, s_valid, s_last,
        output s_ready, m_data, m_valid, m_err, frame_done, underrun, busy
    );
endinterface

// File: rtl/eth_tx_framer.sv
// Ethernet TX framer: preamble+SFD, payload, zero pad to minimum length,
// CRC-32 FCS (reflected 0xEDB88320), then the inter-frame gap. One byte per clock.
//
//  state    | meaning
//  ---------+---------------------------------------------------------------
//  IDLE     | waiting for s_valid; the detect cycle launches the first 0x55
//  PREAMBLE | remaining 0x55 bytes, then the 0xD5 SFD
//  PAYLOAD  | forwarding payload bytes; a starved cycle aborts the frame
//  PAD      | 0x00 fill up to MIN_FRAME bytes
//  FCS      | four inverted CRC bytes, LSB first
//  DRAIN    | discard remainder of an aborted frame up to s_last
//  IFG      | IFG_LEN idle line cycles
module eth_tx_framer #(
    parameter int PREAMBLE_LEN = 7,
    parameter int MIN_FRAME    = 60,
    parameter int IFG_LEN      = 12,
    parameter int CNT_W        = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    eth_tx_framer_if.slave bus
);
    localparam int                 TMR_W    = 16;
    localparam logic [31:0]        POLY     = 32'hEDB88320;
    localparam logic [TMR_W-1:0]   PRE_LOAD = TMR_W'(PREAMBLE_LEN > 0 ? PREAMBLE_LEN - 1 : 0);
    localparam logic [TMR_W-1:0]   IFG_LOAD = TMR_W'(IFG_LEN > 0 ? IFG_LEN - 1 : 0);
    localparam logic [CNT_W:0]     MIN_V    = (CNT_W + 1)'(MIN_FRAME);

    typedef enum logic [2:0] {IDLE, PREAMBLE, PAYLOAD, PAD, FCS, DRAIN, IFG} state_t;

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_sat;
    logic [CNT_W:0]     cnt_inc;
    logic [31:0]        crc_q, crc_d;
    logic [7:0]         data_q, data_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;
    logic               done_q, done_d;
    logic               ur_q, ur_d;
    logic               ready;

    function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        c = c_in ^ {24'h0, d};
        for (int b = 0; b < 8; b++) begin
            c = c[0] ? ((c >> 1) ^ POLY) : (c >> 1);
        end
        return c;
    endfunction

    // cnt_inc keeps the carry so a saturated counter never looks short of MIN_FRAME
    assign cnt_inc = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    assign cnt_sat = (&cnt_q) ? cnt_q : cnt_inc[CNT_W-1:0];

    // next-state, counter, CRC and next line byte for every state
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        cnt_d   = cnt_q;
        crc_d   = crc_q;
        data_d  = 8'h00;
        valid_d = 1'b0;
        err_d   = 1'b0;
        done_d  = 1'b0;
        ur_d    = 1'b0;
        ready   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.s_valid) begin
                    crc_d   = 32'hFFFFFFFF;
                    cnt_d   = '0;
                    valid_d = 1'b1;
                    if (PREAMBLE_LEN == 0) begin
                        data_d  = 8'hD5;
                        state_d = PAYLOAD;
                    end else begin
                        data_d  = 8'h55;
                        tmr_d   = PRE_LOAD;
                        state_d = PREAMBLE;
                    end
                end
            end
            PREAMBLE: begin
                valid_d = 1'b1;
                if (tmr_q == '0) begin
                    data_d  = 8'hD5;
                    state_d = PAYLOAD;
                end else begin
                    data_d = 8'h55;
                    tmr_d  = tmr_q - 1'b1;
                end
            end
            PAYLOAD: begin
                ready   = 1'b1;
                valid_d = 1'b1;
                if (bus.s_valid) begin
                    data_d = bus.s_data;
                    crc_d  = crc_byte(crc_q, bus.s_data);
                    cnt_d  = cnt_sat;
                    if (bus.s_last) begin
                        if (cnt_inc < MIN_V) begin
                            state_d = PAD;
                        end else begin
                            tmr_d   = TMR_W'(3);
                            state_d = FCS;
                        end
                    end
                end else begin
                    err_d   = 1'b1;
                    ur_d    = 1'b1;
                    state_d = DRAIN;
                end
            end
            PAD: begin
                valid_d = 1'b1;
                crc_d   = crc_byte(crc_q, 8'h00);
                cnt_d   = cnt_sat;
                if (cnt_inc >= MIN_V) begin
                    tmr_d   = TMR_W'(3);
                    state_d = FCS;
                end
            end
            FCS: begin
                valid_d = 1'b1;
                case (tmr_q[1:0])
                    2'd3:    data_d = ~crc_q[7:0];
                    2'd2:    data_d = ~crc_q[15:8];
                    2'd1:    data_d = ~crc_q[23:16];
                    default: data_d = ~crc_q[31:24];
                endcase
                if (tmr_q == '0) begin
                    done_d  = 1'b1;
                    tmr_d   = IFG_LOAD;
                    state_d = (IFG_LEN == 0) ? IDLE : IFG;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            DRAIN: begin
                ready = 1'b1;
                if (bus.s_valid && bus.s_last) begin
                    tmr_d   = IFG_LOAD;
                    state_d = (IFG_LEN == 0) ? IDLE : IFG;
                end
            end
            IFG: begin
                if (tmr_q == '0) begin
                    state_d = IDLE;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state, counters and registered line outputs; reset aborts any frame immediately
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            cnt_q   <= '0;
            crc_q   <= 32'hFFFFFFFF;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            ur_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            cnt_q   <= cnt_d;
            crc_q   <= crc_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            done_q  <= done_d;
            ur_q    <= ur_d;
        end
    end

    assign bus.s_ready    = ready;
    assign bus.m_data     = data_q;
    assign bus.m_valid    = valid_q;
    assign bus.m_err      = err_q;
    assign bus.frame_done = done_q;
    assign bus.underrun   = ur_q;
    assign bus.busy       = (state_q != IDLE);
endmodule
